dcache_refill_rd_ctrl: RTL
==========================

Name: dcache_refill_rd_ctrl

Overview:
- Data-cache refill read controller. It accepts a single line-miss request from the dcache miss handler and issues one AXI INCR read burst (AR channel).
- It consumes the R beats, assembles them little-endian into a full cache line, and hands the line to the dcache data/tag write port with a valid/ready handshake.
- It sits between the AXI master port and the dcache refill write path.

Parameters:
- ADDR_W, 32, AXI/physical address width.
- AXI_DW, 8, AXI R data width in bits.
- LINE_W, 16, cache line width in bits; must be an integer multiple of AXI_DW, at least AXI_DW.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- miss_req_i  in  1  refill request from miss handler.
- miss_addr_i  in  ADDR_W  miss byte address.
- miss_gnt_o  out  1  one-cycle pulse: request accepted.
- ar_valid_o  out  1  AXI AR valid.
- ar_ready_i  in  1  AXI AR ready.
- ar_addr_o  out  ADDR_W  line-aligned burst address.
- ar_len_o  out  8  burst length, BEATS-1.
- r_valid_i  in  1  AXI R valid.
- r_ready_o  out  1  AXI R ready.
- r_data_i  in  AXI_DW  R data.
- r_resp_i  in  2  R response.
- r_last_i  in  1  R last.
- line_valid_o  out  1  assembled line available.
- line_ready_i  in  1  dcache accepts line.
- line_data_o  out  LINE_W  assembled line.
- line_addr_o  out  ADDR_W  line-aligned address.
- line_err_o  out  1  line is corrupt; dcache must not mark it valid.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Constants: BEATS = LINE_W/AXI_DW; OFS_W = log2(LINE_W/8) low address bits.
- Reset: FSM goes to IDLE.
  - All outputs 0, including line_data_o, line_addr_o and line_err_o.
  - Beat counter and sticky error cleared.
- IDLE:
  - miss_gnt_o = miss_req_i.
  - On request: latch {miss_addr_i[ADDR_W-1:OFS_W], OFS_W'b0}, clear line buffer, counter and error, then go to AR.
- AR:
  - ar_valid_o = 1; ar_addr_o and ar_len_o are held stable until handshake.
  - On ar_valid_o & ar_ready_i, go to RDATA. No early deassert of ar_valid_o.
- RDATA:
  - r_ready_o = 1.
  - Each accepted beat with count k < BEATS writes line[k*AXI_DW +: AXI_DW]; count increments, saturating at BEATS.
  - r_resp_i[1] set on any beat sets the sticky error.
  - Beat with count >= BEATS (too many beats): data discarded, error set.
  - r_last_i on a beat: go to DELIVER. If that beat is not beat BEATS-1, error set (too few beats).
- DELIVER:
  - line_valid_o = 1.
  - line_data_o, line_addr_o and line_err_o are stable while valid and not ready.
  - On line_ready_i, go to IDLE. miss_gnt_o may pulse in the following cycle, never in the same cycle.
- Latency with zero-wait slaves:
  - gnt at cycle 0, AR at cycle 1, first beat accepted at cycle 2.
  - line_valid_o at cycle 2+BEATS.
- Only one outstanding burst at a time; miss_gnt_o is never asserted while busy.
- Reset mid-operation clears state immediately. Any in-flight AXI burst is untracked after reset; system reset covers the slave too.

Optional Feature:
- Macro: DCACHE_REFILL_TIMEOUT_EN.
- Enabled:
  - Adds a watchdog counter, cleared on entering AR and on each accepted beat.
  - Expiry at TIMEOUT_CYC in AR: ar_valid_o stays asserted (AXI rule); a sticky timeout flag is set and forces line_err_o.
  - Expiry in RDATA: error set and FSM goes to DRAIN.
    - DRAIN: r_ready_o = 1, beats discarded until r_last_i, then DELIVER with line_err_o = 1.
- Disabled: no counter, no DRAIN state; waiting is unbounded.

Decomposition:
- Shared package dcache_refill_pkg holds:
  - state enum {IDLE, AR, RDATA, DRAIN, DELIVER};
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - BEATS and OFS_W helper functions.
- One natural sub-module: dcache_refill_line_asm (beat counter plus line buffer write/clear, over-run and under-run detection). The FSM stays in the top.

Test Plan:
- AXI_DW=8, LINE_W=16; miss_addr 0x1003; ar_ready immediate; beats 0xAA then 0xBB (last) -> ar_addr 0x1002, ar_len 1, line_data 0xBBAA, err 0, valid at cycle 4.
- Same request; line_ready_i held low 5 cycles and miss_req_i held high -> line outputs stable, no second gnt until one cycle after the ready handshake.
- Beat 0 with resp SLVERR, beat 1 OKAY -> line_err_o = 1, data still 0xBBAA.
- r_last_i on beat 0 -> DELIVER with err = 1.
- Three beats with r_last on the third -> third beat discarded, err = 1, data from first two beats.
- With DCACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYC=8: one beat, then r_valid low 8 cycles -> DRAIN; late beat with last -> line_valid_o with err = 1.

Source files
------------

// File: rtl/dcache_refill_pkg.sv
// Shared types and helpers for the dcache refill read controller.
// FSM state encoding, AXI response codes and line geometry helpers.
package dcache_refill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        RDATA,
        DRAIN,
        DELIVER
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic int beats(input int line_w, input int axi_dw);
        return line_w / axi_dw;
    endfunction

    function automatic int ofs_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/dcache_refill_line_asm.sv
// Beat counter and line buffer: writes beats little-endian, flags
// over-run, under-run and error responses into one sticky error bit.
// Ports: clk_i, rst_ni, clear, beat, data, resp, last, err_set -> line, err.
module dcache_refill_line_asm
    import dcache_refill_pkg::*;
#(
    parameter int AXI_DW = 8,
    parameter int LINE_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear,
    input  logic              beat,
    input  logic [AXI_DW-1:0] data,
    input  logic [1:0]        resp,
    input  logic              last,
    input  logic              err_set,
    output logic [LINE_W-1:0] line,
    output logic              err
);

    localparam int BEATS = beats(LINE_W, AXI_DW);
    localparam int CNT_W = $clog2(BEATS + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] line_q;
    logic              err_q;
    logic              full;
    logic              short;
    logic              bad_resp;

    assign full     = (cnt_q == CNT_W'(BEATS));
    // last arriving anywhere but the final slot means a short burst
    assign short    = last && (cnt_q != CNT_W'(BEATS - 1));
    assign bad_resp = (resp == AXI_RESP_SLVERR) ||
                      (resp == AXI_RESP_DECERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
        end else if (clear) begin
            cnt_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (beat) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (cnt_q == CNT_W'(k))
                        line_q[k*AXI_DW +: AXI_DW] <= data;
                end
                if (!full)
                    cnt_q <= cnt_q + 1'b1;
            end
            if (err_set || (beat && (bad_resp || full || short)))
                err_q <= 1'b1;
        end
    end

    assign line = line_q;
    assign err  = err_q;

endmodule

// File: rtl/dcache_refill_rd_ctrl.sv
// Dcache refill read controller: one AXI INCR burst per line miss,
// beats assembled into a line and handed to the dcache write port.
// Ports: miss req/gnt, AXI AR/R master, line valid/ready, busy.
// Optional watchdog with DRAIN state: define DCACHE_REFILL_TIMEOUT_EN.
module dcache_refill_rd_ctrl
    import dcache_refill_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int AXI_DW      = 8,
    parameter int LINE_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              miss_req_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              miss_gnt_o,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [ADDR_W-1:0] ar_addr_o,
    output logic [7:0]        ar_len_o,
    input  logic              r_valid_i,
    output logic              r_ready_o,
    input  logic [AXI_DW-1:0] r_data_i,
    input  logic [1:0]        r_resp_i,
    input  logic              r_last_i,
    output logic              line_valid_o,
    input  logic              line_ready_i,
    output logic [LINE_W-1:0] line_data_o,
    output logic [ADDR_W-1:0] line_addr_o,
    output logic              line_err_o,
    output logic              busy_o
);

    localparam int BEATS = beats(LINE_W, AXI_DW);
    localparam int OFS_W = ofs_w(LINE_W);
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS_W) - 1);

    if ((LINE_W % AXI_DW) != 0 || LINE_W < AXI_DW ||
        TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("dcache_refill_rd_ctrl: bad parameters");
    end

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              clear;
    logic              beat;
    logic              err_set;
    logic              to_flag;
    logic              asm_err;
    logic              expired;

    assign clear = (state_q == IDLE) && miss_req_i;
    // DRAIN beats are dropped, so only RDATA feeds the assembler
    assign beat  = (state_q == RDATA) && r_valid_i;

`ifdef DCACHE_REFILL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            to_q;
    logic            waiting;

    assign waiting = (state_q == AR) || (state_q == RDATA);
    assign expired = waiting && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            if (clear) begin
                wd_q <= '0;
                to_q <= 1'b0;
            end else if (beat) begin
                wd_q <= '0;
            end else if (waiting && !expired) begin
                wd_q <= wd_q + 1'b1;
            end
            // AR must keep valid high, so only flag the line
            if (state_q == AR && expired)
                to_q <= 1'b1;
        end
    end

    assign to_flag = to_q;
    assign err_set = (state_q == RDATA) && expired && !r_valid_i;
`else
    assign expired = 1'b0;
    assign to_flag = 1'b0;
    assign err_set = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (clear)
                addr_q <= miss_addr_i & ~OFS_MASK;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss_req_i) state_d = AR;
            AR:      if (ar_ready_i) state_d = RDATA;
            RDATA: begin
                if (r_valid_i && r_last_i)
                    state_d = DELIVER;
                else if (expired && !r_valid_i)
                    state_d = DRAIN;
            end
`ifdef DCACHE_REFILL_TIMEOUT_EN
            DRAIN:   if (r_valid_i && r_last_i) state_d = DELIVER;
`endif
            DELIVER: if (line_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miss_gnt_o   = 1'b0;
        ar_valid_o   = 1'b0;
        ar_len_o     = 8'd0;
        r_ready_o    = 1'b0;
        line_valid_o = 1'b0;
        busy_o       = (state_q != IDLE);
        unique case (state_q)
            IDLE:    miss_gnt_o = miss_req_i;
            AR: begin
                ar_valid_o = 1'b1;
                ar_len_o   = 8'(BEATS - 1);
            end
            RDATA:   r_ready_o = 1'b1;
            DRAIN:   r_ready_o = 1'b1;
            DELIVER: line_valid_o = 1'b1;
            default: ;
        endcase
    end

    dcache_refill_line_asm #(
        .AXI_DW (AXI_DW),
        .LINE_W (LINE_W)
    ) u_line_asm (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (clear),
        .beat    (beat),
        .data    (r_data_i),
        .resp    (r_resp_i),
        .last    (r_last_i),
        .err_set (err_set),
        .line    (line_data_o),
        .err     (asm_err)
    );

    assign ar_addr_o   = addr_q;
    assign line_addr_o = addr_q;
    assign line_err_o  = asm_err | to_flag;

endmodule
